// File: rtl/spi_reg_pkg.sv
// Shared types and constants for the SPI register slave.
package spi_reg_pkg;

    typedef enum logic [1:0] {IDLE, CMD, DATA} spi_state_t;

    localparam int CMD_RW_BIT = 7;
    localparam int SPI_BYTE_W = 8;
    localparam int BIT_CNT_W  = $clog2(SPI_BYTE_W);

endpackage

// File: rtl/cdc_sync.sv
// Generic N-flop synchroniser for a single asynchronous input bit.
module cdc_sync #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) chain <= {STAGES{RESET_VAL}};
        else        chain <= {chain[STAGES-2:0], d};
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/spi_reg_slave.sv
// SPI mode-0 slave decoding {rw, addr} + data frames onto a single-cycle register bus.
// Define SPI_AUTO_INC_EN to make reg_addr_o advance after every data byte strobe.
module spi_reg_slave
    import spi_reg_pkg::*;
#(
    parameter int ADDR_W      = 7,
    parameter int DATA_W      = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              spi_cs_i,
    input  logic              spi_sclk_i,
    input  logic              spi_mosi_i,
    output logic              spi_miso_o,
    output logic              spi_miso_oe,
    output logic [ADDR_W-1:0] reg_addr_o,
    output logic [DATA_W-1:0] reg_wdata_o,
    output logic              reg_we_o,
    output logic              reg_re_o,
    input  logic [DATA_W-1:0] reg_rdata_i,
    output logic              busy_o
);

    logic cs_s, sclk_s, mosi_s;
    logic cs_prev, sclk_prev;

    // NOTE: CS idles high, so its synchroniser resets to 1 to avoid a false frame start.
    cdc_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_cs (
        .clk(clk), .rst_n(rst_n), .d(spi_cs_i), .q(cs_s)
    );
    cdc_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
        .clk(clk), .rst_n(rst_n), .d(spi_sclk_i), .q(sclk_s)
    );
    cdc_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
        .clk(clk), .rst_n(rst_n), .d(spi_mosi_i), .q(mosi_s)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cs_prev   <= 1'b1;
            sclk_prev <= 1'b0;
        end else begin
            cs_prev   <= cs_s;
            sclk_prev <= sclk_s;
        end
    end

    logic cs_fall, cs_rise, sclk_rise, sclk_fall;
    assign cs_fall   =  cs_prev   & ~cs_s;
    assign cs_rise   = ~cs_prev   &  cs_s;
    assign sclk_rise = ~sclk_prev &  sclk_s;
    assign sclk_fall =  sclk_prev & ~sclk_s;

    spi_state_t           state_q, state_d;
    logic [BIT_CNT_W-1:0] bit_cnt;
    logic [DATA_W-1:0]    rx_q, tx_q, rx_next;
    logic                 rw_q, miso_bit, re_d;
    logic                 shift_en, byte_done;

    // SCLK is only honoured inside a frame, which also covers edges seen with CS high.
    assign shift_en  = sclk_rise && (state_q != IDLE);
    assign byte_done = shift_en && (bit_cnt == BIT_CNT_W'(SPI_BYTE_W - 1));
    assign rx_next   = {rx_q[DATA_W-2:0], mosi_s};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (cs_fall) state_d = CMD;
            CMD:     if (byte_done) state_d = DATA;
            DATA:    state_d = DATA;
            default: state_d = IDLE;
        endcase
        // A byte completing in the same cycle is still strobed by the datapath below.
        if (cs_rise) state_d = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt     <= '0;
            rx_q        <= '0;
            tx_q        <= '0;
            rw_q        <= 1'b0;
            miso_bit    <= 1'b0;
            re_d        <= 1'b0;
            reg_addr_o  <= '0;
            reg_wdata_o <= '0;
            reg_we_o    <= 1'b0;
            reg_re_o    <= 1'b0;
        end else begin
            reg_we_o <= 1'b0;
            reg_re_o <= 1'b0;
            re_d     <= reg_re_o;
`ifdef SPI_AUTO_INC_EN
            // Advance once the strobe and (for reads) the data capture are done.
            if (reg_we_o || re_d) reg_addr_o <= reg_addr_o + ADDR_W'(1);
`endif
            if (cs_fall) begin
                bit_cnt  <= '0;
                rx_q     <= '0;
                miso_bit <= 1'b0;
            end else if (shift_en) begin
                bit_cnt <= bit_cnt + BIT_CNT_W'(1);
                rx_q    <= rx_next;
                if (byte_done) begin
                    if (state_q == CMD) begin
                        rw_q       <= rx_next[CMD_RW_BIT];
                        reg_addr_o <= rx_next[ADDR_W-1:0];
                        reg_re_o   <= ~rx_next[CMD_RW_BIT];
                    end else if (rw_q) begin
                        reg_wdata_o <= rx_next;
                        reg_we_o    <= 1'b1;
                    end else begin
                        reg_re_o <= 1'b1;
                    end
                end
            end
            if (cs_rise) begin
                bit_cnt <= '0;
                rx_q    <= '0;
            end
            if (re_d) begin
                tx_q <= reg_rdata_i;
            end else if (sclk_fall && state_q == DATA && !rw_q) begin
                miso_bit <= tx_q[DATA_W-1];
                tx_q     <= {tx_q[DATA_W-2:0], 1'b0};
            end
        end
    end

    assign busy_o      = ~cs_s;
    assign spi_miso_oe = busy_o && !rw_q && (state_q == DATA);
    assign spi_miso_o  = spi_miso_oe & miso_bit;

endmodule

// File: tb/tb_spi_reg_slave.sv
// Directed and scoreboarded bench for spi_reg_slave; honours SPI_AUTO_INC_EN.
module tb_spi_reg_slave;

    logic       clk, rst_n;
    logic       cs, sclk, mosi;
    logic       miso, miso_oe, we, re, busy;
    logic [6:0] addr;
    logic [7:0] wdata, rdata;

    logic [7:0] regs     [128];
    logic [7:0] exp_regs [128];
    logic [6:0] wr_addr_q[$];
    logic [7:0] wr_data_q[$];
    logic [6:0] rd_addr_q[$];

    int pass_cnt = 0;
    int chk_cnt  = 0;
    int both_cnt = 0;
    int half     = 4;

    spi_reg_slave #(.ADDR_W(7), .DATA_W(8), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .spi_cs_i(cs), .spi_sclk_i(sclk), .spi_mosi_i(mosi),
        .spi_miso_o(miso), .spi_miso_oe(miso_oe),
        .reg_addr_o(addr), .reg_wdata_o(wdata),
        .reg_we_o(we), .reg_re_o(re), .reg_rdata_i(rdata),
        .busy_o(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register-file model: combinational read, write on strobe.
    assign rdata = regs[addr];

    always @(negedge clk) begin
        if (we) begin
            wr_addr_q.push_back(addr);
            wr_data_q.push_back(wdata);
            regs[addr] = wdata;
        end
        if (re) rd_addr_q.push_back(addr);
        if (we && re) both_cnt++;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish, checks so far %0d/%0d", pass_cnt, chk_cnt);
        $fatal(1);
    end

    task automatic clear_logs();
        wr_addr_q.delete();
        wr_data_q.delete();
        rd_addr_q.delete();
    endtask

    task automatic start_frame();
        @(negedge clk);
        sclk = 1'b0;
        cs   = 1'b0;
        repeat (half) @(negedge clk);
    endtask

    task automatic end_frame();
        repeat (half) @(negedge clk);
        cs = 1'b1;
        repeat (2 * half + 6) @(negedge clk);
    endtask

    // Shift nbits of tx MSB first; miso and oe are sampled at the end of each high phase.
    task automatic spi_bits(input logic [7:0] tx, input int nbits,
                            output logic [7:0] rx, output logic [7:0] oe_mask);
        rx      = '0;
        oe_mask = '0;
        for (int i = 0; i < nbits; i++) begin
            mosi = tx[7-i];
            repeat (half) @(negedge clk);
            sclk = 1'b1;
            repeat (half) @(negedge clk);
            rx[7-i]      = miso;
            oe_mask[7-i] = miso_oe;
            sclk = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; cs = 1'b1; sclk = 1'b0; mosi = 1'b0;
        repeat (3) @(negedge clk);
        chk_cnt++;
        if ({we, re, busy, miso_oe, miso} !== 5'b0)
            $display("FAIL reset_ctrl: got %b expected 00000", {we, re, busy, miso_oe, miso});
        else pass_cnt++;
        chk_cnt++;
        if ({addr, wdata} !== 15'h0)
            $display("FAIL reset_bus: got addr %h wdata %h expected 00 00", addr, wdata);
        else pass_cnt++;
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        chk_cnt++;
        if (busy !== 1'b0) $display("FAIL reset_busy_idle: got %b expected 0", busy);
        else pass_cnt++;
    endtask

    task automatic test_write();
        logic [7:0] rx, m;
        clear_logs();
        start_frame();
        spi_bits(8'h85, 8, rx, m);
        chk_cnt++;
        if (busy !== 1'b1) $display("FAIL t1_busy: got %b expected 1", busy);
        else pass_cnt++;
        spi_bits(8'hA5, 8, rx, m);
        end_frame();
        chk_cnt++;
        if (wr_addr_q.size() !== 1) $display("FAIL t1_we_count: got %0d expected 1", wr_addr_q.size());
        else pass_cnt++;
        chk_cnt++;
        if (wr_addr_q[0] !== 7'h05) $display("FAIL t1_addr: got %h expected 05", wr_addr_q[0]);
        else pass_cnt++;
        chk_cnt++;
        if (wr_data_q[0] !== 8'hA5) $display("FAIL t1_wdata: got %h expected a5", wr_data_q[0]);
        else pass_cnt++;
        chk_cnt++;
        if (rd_addr_q.size() !== 0 || busy !== 1'b0)
            $display("FAIL t1_no_read_idle: got re %0d busy %b expected 0 0", rd_addr_q.size(), busy);
        else pass_cnt++;
    endtask

    task automatic test_read();
        logic [7:0] rx, m;
        logic [6:0] exp_next;
`ifdef SPI_AUTO_INC_EN
        exp_next = 7'h11;
`else
        exp_next = 7'h10;
`endif
        regs[7'h10] = 8'h3C;
        regs[7'h11] = 8'h77;
        clear_logs();
        start_frame();
        spi_bits(8'h10, 8, rx, m);
        chk_cnt++;
        if (m[7:1] !== 7'b0) $display("FAIL t2_oe_cmd: got %b expected 0000000", m[7:1]);
        else pass_cnt++;
        spi_bits(8'h00, 8, rx, m);
        chk_cnt++;
        if (rx !== 8'h3C) $display("FAIL t2_miso: got %h expected 3c", rx);
        else pass_cnt++;
        chk_cnt++;
        if (m !== 8'hFF) $display("FAIL t2_oe_data: got %b expected 11111111", m);
        else pass_cnt++;
        end_frame();
        chk_cnt++;
        if (miso_oe !== 1'b0 || miso !== 1'b0)
            $display("FAIL t2_oe_after: got oe %b miso %b expected 0 0", miso_oe, miso);
        else pass_cnt++;
        chk_cnt++;
        if (rd_addr_q.size() !== 2 || wr_addr_q.size() !== 0)
            $display("FAIL t2_strobes: got re %0d we %0d expected 2 0", rd_addr_q.size(), wr_addr_q.size());
        else pass_cnt++;
        chk_cnt++;
        if (rd_addr_q[0] !== 7'h10) $display("FAIL t2_addr: got %h expected 10", rd_addr_q[0]);
        else pass_cnt++;
        chk_cnt++;
        if (rd_addr_q[1] !== exp_next) $display("FAIL t2_addr_next: got %h expected %h", rd_addr_q[1], exp_next);
        else pass_cnt++;
    endtask

    task automatic test_burst();
        logic [7:0] rx, m;
        logic [6:0] exp_a2;
`ifdef SPI_AUTO_INC_EN
        exp_a2 = 7'h00;
`else
        exp_a2 = 7'h7F;
`endif
        clear_logs();
        start_frame();
        spi_bits(8'hFF, 8, rx, m);
        spi_bits(8'h11, 8, rx, m);
        spi_bits(8'h22, 8, rx, m);
        end_frame();
        chk_cnt++;
        if (wr_addr_q.size() !== 2) $display("FAIL t3_we_count: got %0d expected 2", wr_addr_q.size());
        else pass_cnt++;
        chk_cnt++;
        if (wr_addr_q[0] !== 7'h7F || wr_data_q[0] !== 8'h11)
            $display("FAIL t3_first: got %h=%h expected 7f=11", wr_addr_q[0], wr_data_q[0]);
        else pass_cnt++;
        chk_cnt++;
        if (wr_addr_q[1] !== exp_a2 || wr_data_q[1] !== 8'h22)
            $display("FAIL t3_second: got %h=%h expected %h=22", wr_addr_q[1], wr_data_q[1], exp_a2);
        else pass_cnt++;
    endtask

    task automatic test_abort();
        logic [7:0] rx, m;
        clear_logs();
        start_frame();
        spi_bits(8'h85, 8, rx, m);
        spi_bits(8'h5A, 5, rx, m);
        end_frame();
        chk_cnt++;
        if (wr_addr_q.size() !== 0 || rd_addr_q.size() !== 0)
            $display("FAIL t4_no_strobe: got we %0d re %0d expected 0 0", wr_addr_q.size(), rd_addr_q.size());
        else pass_cnt++;
        chk_cnt++;
        if (busy !== 1'b0 || miso_oe !== 1'b0)
            $display("FAIL t4_idle: got busy %b oe %b expected 0 0", busy, miso_oe);
        else pass_cnt++;
        start_frame();
        spi_bits(8'h86, 8, rx, m);
        spi_bits(8'h2A, 8, rx, m);
        end_frame();
        chk_cnt++;
        if (wr_addr_q.size() !== 1 || wr_addr_q[0] !== 7'h06 || wr_data_q[0] !== 8'h2A)
            $display("FAIL t4_recover: got n=%0d %h=%h expected n=1 06=2a",
                     wr_addr_q.size(), wr_addr_q[0], wr_data_q[0]);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0] rx, m;
        start_frame();
        spi_bits(8'h85, 8, rx, m);
        spi_bits(8'hC3, 3, rx, m);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk_cnt++;
        if ({we, re, busy, miso_oe, miso, addr, wdata} !== 20'h0)
            $display("FAIL t5_async_reset: got %h expected 00000", {we, re, busy, miso_oe, miso, addr, wdata});
        else pass_cnt++;
        cs = 1'b1;
        sclk = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        clear_logs();
        for (int i = 0; i < 16; i++) begin
            mosi = 1'($urandom);
            repeat (half) @(negedge clk);
            sclk = 1'b1;
            repeat (half) @(negedge clk);
            sclk = 1'b0;
        end
        repeat (8) @(negedge clk);
        chk_cnt++;
        if (wr_addr_q.size() !== 0 || rd_addr_q.size() !== 0 || busy !== 1'b0)
            $display("FAIL t5_cs_high_ignored: got we %0d re %0d busy %b expected 0 0 0",
                     wr_addr_q.size(), rd_addr_q.size(), busy);
        else pass_cnt++;
        start_frame();
        spi_bits(8'h87, 8, rx, m);
        spi_bits(8'h99, 8, rx, m);
        end_frame();
        chk_cnt++;
        if (wr_addr_q.size() !== 1 || wr_addr_q[0] !== 7'h07 || wr_data_q[0] !== 8'h99)
            $display("FAIL t5_recover: got n=%0d %h=%h expected n=1 07=99",
                     wr_addr_q.size(), wr_addr_q[0], wr_data_q[0]);
        else pass_cnt++;
    endtask

    task automatic test_random_frames();
        logic       rw;
        logic [6:0] a, ea;
        logic [7:0] d, rx, m;
        logic [6:0] exp_wa[3];
        logic [7:0] exp_wd[3];
        int         n;
        half = 4;
        for (int i = 0; i < 128; i++) begin
            regs[i]     = 8'(i * 7 + 3);
            exp_regs[i] = 8'(i * 7 + 3);
        end
        for (int f = 0; f < 64; f++) begin
            rw = 1'($urandom);
            a  = 7'($urandom);
            n  = $urandom_range(1, 3);
            clear_logs();
            start_frame();
            spi_bits({rw, a}, 8, rx, m);
            for (int k = 0; k < n; k++) begin
`ifdef SPI_AUTO_INC_EN
                ea = a + 7'(k);
`else
                ea = a;
`endif
                d = 8'($urandom);
                spi_bits(d, 8, rx, m);
                if (rw) begin
                    exp_regs[ea] = d;
                    exp_wa[k]    = ea;
                    exp_wd[k]    = d;
                end else begin
                    chk_cnt++;
                    if (rx !== exp_regs[ea])
                        $display("FAIL t6_read f%0d b%0d: got %h expected %h", f, k, rx, exp_regs[ea]);
                    else pass_cnt++;
                end
            end
            end_frame();
            if (rw) begin
                chk_cnt++;
                if (wr_addr_q.size() !== n || rd_addr_q.size() !== 0)
                    $display("FAIL t6_we_count f%0d: got we %0d re %0d expected %0d 0",
                             f, wr_addr_q.size(), rd_addr_q.size(), n);
                else pass_cnt++;
                for (int k = 0; k < n; k++) begin
                    chk_cnt++;
                    if (wr_addr_q[k] !== exp_wa[k] || wr_data_q[k] !== exp_wd[k])
                        $display("FAIL t6_write f%0d b%0d: got %h=%h expected %h=%h",
                                 f, k, wr_addr_q[k], wr_data_q[k], exp_wa[k], exp_wd[k]);
                    else pass_cnt++;
                end
            end else begin
                chk_cnt++;
                if (rd_addr_q.size() !== n + 1 || wr_addr_q.size() !== 0)
                    $display("FAIL t6_re_count f%0d: got re %0d we %0d expected %0d 0",
                             f, rd_addr_q.size(), wr_addr_q.size(), n + 1);
                else pass_cnt++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_burst();
        test_abort();
        test_reset_mid_frame();
        test_random_frames();
        chk_cnt++;
        if (both_cnt !== 0) $display("FAIL we_re_exclusive: got %0d overlaps expected 0", both_cnt);
        else pass_cnt++;
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
